// File: rtl/mul_hilo_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mul_hilo_seq_pkg : state encoding and sizing constants for mul_hilo_seq
// Revision 1.0
// ----------------------------------------------------------------------------
package mul_hilo_seq_pkg;

  localparam int HL_W        = 32;
  localparam int MUL_LAT_MIN = 1;
  localparam int MUL_LAT_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mul_hilo_seq_alu_mul.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mul_hilo_seq_alu_mul : combinational 32x32 signed multiplier, 64-bit product
// Revision 1.0
// ----------------------------------------------------------------------------
module mul_hilo_seq_alu_mul
  import mul_hilo_seq_pkg::*;
(
  input  logic [HL_W-1:0]   a,
  input  logic [HL_W-1:0]   b,
  output logic [2*HL_W-1:0] p
);

  logic [2*HL_W-1:0] a_ext;
  logic [2*HL_W-1:0] b_ext;

  // Low 64 bits of the product of sign-extended operands is the exact signed product.
  assign a_ext = {{HL_W{a[HL_W-1]}}, a};
  assign b_ext = {{HL_W{b[HL_W-1]}}, b};
  assign p     = a_ext * b_ext;

endmodule
`default_nettype wire

// File: rtl/mul_hilo_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mul_hilo_seq : multicycle HI/LO sequencer around a combinational multiplier
// Revision 1.0
// ----------------------------------------------------------------------------
module mul_hilo_seq
  import mul_hilo_seq_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic [31:0]     a_in,
  input  logic [31:0]     b_in,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic [31:0]     bus_in,
  output logic            busy,
  output logic            done,
  output logic [31:0]     hi_out,
  output logic [31:0]     lo_out
);

  localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [HL_W-1:0]   op_a_q, op_a_d;
  logic [HL_W-1:0]   op_b_q, op_b_d;
  logic [HL_W-1:0]   hi_q, hi_d;
  logic [HL_W-1:0]   lo_q, lo_d;
  logic [2*HL_W-1:0] prod;

  // op_a/op_b -> prod -> hi/lo is a MUL_LAT-cycle multicycle path.
  mul_hilo_seq_alu_mul alu_mul (
    .a (op_a_q),
    .b (op_b_q),
    .p (prod)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (mthi) hi_d = bus_in;
        if (mtlo) lo_d = bus_in;
        if (start) begin
          op_a_d  = a_in;
          op_b_d  = b_in;
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          {hi_d, lo_d} = prod;
          state_d      = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy   = (state_q == ST_WAIT);
  assign done   = (state_q == ST_DONE);
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_hilo_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mul_hilo_seq : directed self-checking bench for mul_hilo_seq (MUL_LAT=2)
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_mul_hilo_seq;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] bus_in = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int checks   = 0;
  int failures = 0;
  int bc;
  int done_seen;

  mul_hilo_seq #(.MUL_LAT(2)) dut (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .bus_in (bus_in),
    .busy   (busy),
    .done   (done),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one multiply, return busy-cycle count; leaves the bench sampling in DONE.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, output int busy_cycles);
    int n;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    step();
    start = 1'b0;
    busy_cycles = 0;
    n = 0;
    while (!done && n < 20) begin
      if (busy) busy_cycles++;
      step();
      n++;
    end
    check("done_timeout", {63'd0, done}, 64'd1);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hi", {32'd0, hi_out}, 64'd0);
    check("rst_lo", {32'd0, lo_out}, 64'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    step();

    // 7 x -3
    do_mul(32'd7, 32'hFFFF_FFFD, bc);
    check("m1_busy_cycles", 64'(bc), 64'd2);
    check("m1_hi", {32'd0, hi_out}, 64'hFFFF_FFFF);
    check("m1_lo", {32'd0, lo_out}, 64'hFFFF_FFEB);
    step();
    check("m1_done_pulse", {63'd0, done}, 64'd0);
    check("m1_hi_hold", {32'd0, hi_out}, 64'hFFFF_FFFF);

    // most negative squared
    do_mul(32'h8000_0000, 32'h8000_0000, bc);
    check("m2_hi", {32'd0, hi_out}, 64'h4000_0000);
    check("m2_lo", {32'd0, lo_out}, 64'h0000_0000);
    step();

    // most positive squared
    do_mul(32'h7FFF_FFFF, 32'h7FFF_FFFF, bc);
    check("m3_hi", {32'd0, hi_out}, 64'h3FFF_FFFF);
    check("m3_lo", {32'd0, lo_out}, 64'h0000_0001);
    step();

    // start/mthi during WAIT ignored; start held through DONE chains a second op
    a_in = 32'd5; b_in = 32'd6; start = 1'b1;
    step();
    check("w_busy0", {63'd0, busy}, 64'd1);
    a_in = 32'd0; mthi = 1'b1; bus_in = 32'hDEAD_BEEF;
    step();
    check("w_busy1", {63'd0, busy}, 64'd1);
    check("w_mthi_ignored", {32'd0, hi_out}, 64'h3FFF_FFFF);
    mthi = 1'b0;
    step();
    check("w_done", {63'd0, done}, 64'd1);
    check("w_hi", {32'd0, hi_out}, 64'h0);
    check("w_lo", {32'd0, lo_out}, 64'd30);
    a_in = 32'hFFFF_FFFE; b_in = 32'hFFFF_FFFC;
    step();
    check("b2b_busy", {63'd0, busy}, 64'd1);
    check("b2b_done", {63'd0, done}, 64'd0);
    start = 1'b0;
    step();
    check("b2b_busy1", {63'd0, busy}, 64'd1);
    step();
    check("b2b_done2", {63'd0, done}, 64'd1);
    check("b2b_hi", {32'd0, hi_out}, 64'h0);
    check("b2b_lo", {32'd0, lo_out}, 64'd8);
    step();

    // bus writes in IDLE
    mthi = 1'b1; bus_in = 32'hDEAD_BEEF;
    step();
    check("mthi_hi", {32'd0, hi_out}, 64'hDEAD_BEEF);
    check("mthi_lo", {32'd0, lo_out}, 64'd8);
    mtlo = 1'b1; bus_in = 32'h1234_5678;
    step();
    check("both_hi", {32'd0, hi_out}, 64'h1234_5678);
    check("both_lo", {32'd0, lo_out}, 64'h1234_5678);
    mthi = 1'b0; mtlo = 1'b0;

    // bus write on the accepting edge, later overwritten by the product
    a_in = 32'd1; b_in = 32'd1; start = 1'b1; mthi = 1'b1; bus_in = 32'hAAAA_5555;
    step();
    start = 1'b0; mthi = 1'b0;
    check("acc_mthi_hi", {32'd0, hi_out}, 64'hAAAA_5555);
    step();
    step();
    check("acc_prod_done", {63'd0, done}, 64'd1);
    check("acc_prod_hi", {32'd0, hi_out}, 64'h0);
    check("acc_prod_lo", {32'd0, lo_out}, 64'd1);
    step();

    // asynchronous clear mid-WAIT
    a_in = 32'd7; b_in = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    #2 clr = 1'b1;
    #1;
    check("clr_busy", {63'd0, busy}, 64'd0);
    check("clr_done", {63'd0, done}, 64'd0);
    check("clr_hi", {32'd0, hi_out}, 64'd0);
    check("clr_lo", {32'd0, lo_out}, 64'd0);
    step();
    clr = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) done_seen++;
      step();
    end
    check("clr_no_done", 64'(done_seen), 64'd0);
    check("clr_lo_kept0", {32'd0, lo_out}, 64'd0);
    do_mul(32'hFFFF_FFFF, 32'd1, bc);
    check("post_clr_busy_cycles", 64'(bc), 64'd2);
    check("post_clr_hi", {32'd0, hi_out}, 64'hFFFF_FFFF);
    check("post_clr_lo", {32'd0, lo_out}, 64'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_hilo_seq.md
# mul_hilo_seq

Multicycle sequencer that sits directly downstream of the combinational 32x32 signed multiplier `alu_mul`. It latches the operands and holds them stable for a programmable settle window. It then captures the 64-bit signed product into the architectural HI/LO register pair and signals completion. It also services move-to-HI/LO writes from the 32-bit bus, so HI/LO has a single owner.

## Interface
- `MUL_LAT`, default 2: number of clock edges `alu_mul` is given to settle after the operands load. Legal range 1..15.
- `clk`  in  1: system clock, rising edge.
- `clr`  in  1: reset, asynchronous, active-high.
- `start`  in  1: request a multiply of `a_in` x `b_in`. Sampled only in IDLE or DONE.
- `a_in`  in  32: multiplicand, two's complement.
- `b_in`  in  32: multiplier, two's complement.
- `mthi`  in  1: write `bus_in` to HI.
- `mtlo`  in  1: write `bus_in` to LO.
- `bus_in`  in  32: data for `mthi`/`mtlo`.
- `busy`  out  1: high while in WAIT.
- `done`  out  1: one-cycle pulse, high while in DONE.
- `hi_out`  out  32: HI register, product bits 63:32.
- `lo_out`  out  32: LO register, product bits 31:0.

## Operation
- State machine with three states.
  - IDLE: waiting for `start`.
  - WAIT: counting the settle window.
  - DONE: one-cycle completion state.
- Transitions:
  - IDLE or DONE with `start`=1 at an edge: `op_a` <= `a_in`, `op_b` <= `b_in`, `cnt` <= `MUL_LAT`-1, go to WAIT.
  - IDLE with `start`=0: stay in IDLE.
  - DONE with `start`=0: go to IDLE.
  - WAIT with `cnt`!=0: decrement `cnt`, stay in WAIT.
  - WAIT with `cnt`==0: {`hi`,`lo`} <= `alu_mul`.P(`op_a`,`op_b`), go to DONE.
- `start` during WAIT is ignored. `op_a`/`op_b` stay frozen, so `a_in`/`b_in` may change freely.
- `mthi`/`mtlo`:
  - Take effect at the edge only in IDLE or DONE.
  - Ignored in WAIT; no queuing and no error flag.
  - May be asserted together, which writes both halves.
- `mthi`/`mtlo` on the same edge as an accepted `start`: the bus write occurs, and the product later overwrites it.
- Product is full-width signed. No truncation, no overflow flag. HI holds the sign-extended upper half.
- `busy` and `done` are decoded from the registered state only; they have no combinational path from inputs.

## Timing
- Reset (`clr`=1, asynchronous), at any time including mid-operation:
  - State goes to IDLE; `cnt`, `op_a`, `op_b`, `hi`, `lo` go to 0.
  - `busy`=0, `done`=0, `hi_out`=0, `lo_out`=0 immediately.
  - An aborted multiply produces no `done` and no HI/LO write.
- Latency: HI/LO update on the `MUL_LAT`-th edge after the edge that accepted `start`.
  - `done` is high for the cycle immediately following that edge.
  - `busy` is high for exactly `MUL_LAT` cycles.
- Throughput: a `start` held high through DONE is accepted there. Back-to-back multiplies therefore take `MUL_LAT`+1 cycles each.
- `hi_out`/`lo_out` change only on an edge, and hold between writes.
- Multicycle timing constraint: `op_*` -> `alu_mul` -> `hi`/`lo` is a multicycle path of `MUL_LAT` cycles. Timing sign-off must be consistent with the chosen `MUL_LAT`.

## Structure
- Shared package holds:
  - the state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2);
  - the HI/LO width constant (32);
  - the `MUL_LAT` legal bounds.
- One sub-module instance: `alu_mul` (operands `op_a`, `op_b`; output 64-bit P).
- Remaining logic lives in this module: operand registers, 4-bit counter, state register, HI/LO registers.

## Test plan
- `MUL_LAT`=2, `start` with A=7, B=-3:
  - `busy` high for 2 cycles, then `done` for 1 cycle.
  - HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- A=B=0x80000000: HI=0x40000000, LO=0x00000000.
- A=B=0x7FFFFFFF: HI=0x3FFFFFFF, LO=0x00000001.
- During WAIT, change `a_in` to 0 and pulse `start`:
  - Ignored; the result uses the latched operands.
  - Then hold `start` through DONE: a second multiply begins with no IDLE cycle.
- `mthi` with `bus_in`=0xDEADBEEF:
  - During WAIT: HI unchanged.
  - In IDLE: HI=0xDEADBEEF, LO unchanged.
- Assert `clr` mid-WAIT: all outputs read 0 immediately, no `done` pulse. A subsequent `start` completes normally.
